// File: rtl/bist_pkg.sv
// Shared definitions for the full-adder BIST loop: sequencer states and
// the default signature width / golden signature used by TPG, MISR and
// the controller.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } bist_state_t;

    localparam int          DEF_SIG_WIDTH  = 4;
    localparam logic [3:0]  DEF_GOLDEN_SIG = 4'b1011;

endpackage

// File: rtl/bist_pattern_counter.sv
// Clearable, enabled up-counter of applied patterns. term flags the last
// RUN cycle (count == NUM_PATTERNS-1) so the sequencer can leave RUN.
module bist_pattern_counter #(
    parameter int NUM_PATTERNS = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 term
);

    // Clear wins over enable so an abort during RUN lands on zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + 1'b1;
    end

    assign term = (count == CNT_WIDTH'(NUM_PATTERNS - 1));

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: CLEAR (seed TPG, clear MISR) -> RUN for NUM_PATTERNS
// cycles -> COMPARE (sample MISR signature) -> DONE with pass/fail.
// Every output is registered from the next state, so outputs reflect the
// state the FSM is in during that cycle.
module bist_controller
    import bist_pkg::*;
#(
    parameter int                    NUM_PATTERNS = 8,
    parameter int                    SIG_WIDTH    = DEF_SIG_WIDTH,
    parameter logic [SIG_WIDTH-1:0]  GOLDEN_SIG   = SIG_WIDTH'(DEF_GOLDEN_SIG),
    parameter int                    CNT_WIDTH    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SIG_WIDTH-1:0] signature,
    output logic                 bist_mode,
    output logic                 tpg_clr,
    output logic                 tpg_en,
    output logic                 misr_clr,
    output logic                 misr_en,
    output logic [CNT_WIDTH-1:0] pattern_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail
);

    bist_state_t state, state_next;
    logic        cnt_clr, cnt_en, cnt_term;
    logic        sig_match;
    logic        bist_mode_d, clr_d, en_d, busy_d, done_d, pass_d, fail_d;

    // Counter restarts whenever the run is (re)entered or abandoned; it
    // advances only on edges taken while in RUN, so it reads NUM_PATTERNS
    // from COMPARE onward.
    assign cnt_clr = (state_next == IDLE) || (state_next == CLEAR);
    assign cnt_en  = (state == RUN);

    bist_pattern_counter #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (pattern_cnt),
        .term  (cnt_term)
    );

    assign sig_match = (signature == GOLDEN_SIG);

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bist_mode <= 1'b0;
            tpg_clr   <= 1'b0;
            misr_clr  <= 1'b0;
            tpg_en    <= 1'b0;
            misr_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_next;
            bist_mode <= bist_mode_d;
            tpg_clr   <= clr_d;
            misr_clr  <= clr_d;
            tpg_en    <= en_d;
            misr_en   <= en_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail      <= fail_d;
        end
    end

    // Next-state: abort beats everything; start only matters when idle/done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            RUN:     if (cnt_term) state_next = COMPARE;
            COMPARE: state_next = DONE;
            DONE:    if (start) state_next = CLEAR;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // Output values for the cycle spent in state_next.
    always_comb begin
        bist_mode_d = (state_next == CLEAR) || (state_next == RUN) ||
                      (state_next == COMPARE);
        busy_d      = bist_mode_d;
        clr_d       = (state_next == CLEAR);
        en_d        = (state_next == RUN);
        done_d      = (state_next == DONE);
        pass_d      = pass;
        fail_d      = fail;
        if (state_next != DONE) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
        end else if (state == COMPARE) begin
            pass_d = sig_match;
            fail_d = !sig_match;
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: a step-count model of a run is
// compared against every DUT output on each falling edge, plus directed
// scenarios with hand-computed expectations and a randomized phase.
module tb_bist_controller;

    localparam int         N      = 8;
    localparam logic [3:0] GOLDEN = 4'b1011;

    logic       clock, reset, start, abort;
    logic [3:0] signature;
    logic       bist_mode, tpg_clr, tpg_en, misr_clr, misr_en;
    logic [3:0] pattern_cnt;
    logic       busy, done, pass, fail;

    int total = 0;
    int bad   = 0;

    bist_controller dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .signature   (signature),
        .bist_mode   (bist_mode),
        .tpg_clr     (tpg_clr),
        .tpg_en      (tpg_en),
        .misr_clr    (misr_clr),
        .misr_en     (misr_en),
        .pattern_cnt (pattern_cnt),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail        (fail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: t = -1 when idle, otherwise cycles since the run entered
    // CLEAR (0 = clear, 1..N = patterns, N+1 = compare, N+2 = done).
    int t      = -1;
    bit m_pass = 1'b0;
    bit m_fail = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            t <= -1; m_pass <= 1'b0; m_fail <= 1'b0;
        end else if (abort) begin
            t <= -1; m_pass <= 1'b0; m_fail <= 1'b0;
        end else if (t == -1) begin
            if (start) t <= 0;
        end else if (t == N + 1) begin
            m_pass <= (signature == GOLDEN);
            m_fail <= (signature != GOLDEN);
            t <= N + 2;
        end else if (t == N + 2) begin
            if (start) begin t <= 0; m_pass <= 1'b0; m_fail <= 1'b0; end
        end else begin
            t <= t + 1;
        end
    end

    function automatic logic [12:0] expect_vec(int tt, bit mp, bit mf);
        logic       in_run, act, dn;
        logic [3:0] cnt;
        act    = (tt >= 0) && (tt <= N + 1);
        in_run = (tt >= 1) && (tt <= N);
        dn     = (tt == N + 2);
        if (tt <= 0)      cnt = 4'd0;
        else if (tt <= N) cnt = 4'(tt - 1);
        else              cnt = 4'(N);
        return {act, (tt == 0), in_run, (tt == 0), in_run, act, dn,
                mp & dn, mf & dn, cnt};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bist_mode, tpg_clr, tpg_en, misr_clr, misr_en, busy, done,
                pass, fail, pattern_cnt};
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            total++;
            if (dut_vec() !== expect_vec(t, m_pass, m_fail)) begin
                bad++;
                $display("FAIL cycle_check t=%0d actual=%b required=%b",
                         t, dut_vec(), expect_vec(t, m_pass, m_fail));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Pulse start for one cycle, then count edges until done; also counts
    // TPG-enabled cycles and captures tpg_clr/misr_clr of the first cycle.
    task automatic run_once(input logic [3:0] sig, output int edges,
                            output int en_cycles, output bit clr_seen);
        signature = sig;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        clr_seen  = tpg_clr && misr_clr;
        en_cycles = 0;
        edges     = -1;
        for (int k = 1; k <= 40; k++) begin
            if (tpg_en && misr_en) en_cycles++;
            if (done) begin edges = k - 1; break; end
            @(negedge clock);
        end
        if (edges < 0) check("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        int k;
        for (k = 0; k < 40 && pattern_cnt != v; k++) @(negedge clock);
        check("wait_cnt", {28'd0, pattern_cnt}, {28'd0, v});
    endtask

    initial begin
        int  edges, en_cycles;
        bit  clr_seen;
        reset = 1'b0; start = 1'b0; abort = 1'b0; signature = 4'h0;
        #10 reset = 1'b1;
        #50;
        @(negedge clock);
        check("reset_idle", {19'd0, dut_vec()}, 32'd0);

        // Golden run
        run_once(GOLDEN, edges, en_cycles, clr_seen);
        check("golden_latency", edges, 10);
        check("golden_clr", clr_seen, 1);
        check("golden_en_cycles", en_cycles, 8);
        check("golden_pass", {pass, fail, done}, 3'b101);
        check("golden_cnt", pattern_cnt, 8);

        // Faulty signature
        run_once(4'b1010, edges, en_cycles, clr_seen);
        check("faulty_latency", edges, 10);
        check("faulty_result", {pass, fail, done}, 3'b011);

        // Abort mid-run, then a full run
        start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cnt(4'd3);
        abort = 1'b1; @(negedge clock); abort = 1'b0;
        check("abort_idle", {19'd0, dut_vec()}, 32'd0);
        run_once(GOLDEN, edges, en_cycles, clr_seen);
        check("after_abort_en", en_cycles, 8);
        check("after_abort_cnt", pattern_cnt, 8);

        // Asynchronous reset mid-run
        start = 1'b1; @(negedge clock); start = 1'b0;
        wait_cnt(4'd5);
        #2 reset = 1'b0;
        #1 check("async_reset", {19'd0, dut_vec()}, 32'd0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("after_reset_idle", {busy, done}, 2'b00);

        // start held during the run is ignored; start in DONE re-runs
        signature = GOLDEN;
        start = 1'b1;
        repeat (6) @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 20 && !done; k++) @(negedge clock);
        check("held_start_done", {done, pass, pattern_cnt}, {2'b11, 4'd8});
        start = 1'b1; @(negedge clock); start = 1'b0;
        check("rerun_clear", {done, pass, fail, tpg_clr, pattern_cnt},
              {4'b0001, 4'd0});
        repeat (12) @(negedge clock);
        check("rerun_done", {done, pass}, 2'b11);

        // Randomized phase, checked by the per-cycle model compare
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            signature = ($urandom_range(0, 1) == 0) ? GOLDEN : 4'($urandom);
            @(negedge clock);
        end
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
Sequencer for the full-adder BIST loop. It clears the test pattern generator (TPG) and the MISR output-response analyser, then runs the TPG and MISR together for a fixed number of patterns. At the end it compares the final MISR signature to a golden value and reports pass or fail. It sits above the TPG/CUT/MISR datapath and drives the mux that selects between functional and test inputs.

Parameters:
NUM_PATTERNS, 8, number of patterns applied per run (≥1)
SIG_WIDTH, 4, MISR signature width
GOLDEN_SIG, 4'b1011, expected fault-free signature (SIG_WIDTH bits)
CNT_WIDTH, 4, pattern counter width; must satisfy 2**CNT_WIDTH > NUM_PATTERNS

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a BIST run; sampled in IDLE or DONE only
abort  input  1  synchronous abort; returns to IDLE
signature  input  SIG_WIDTH  current MISR output
bist_mode  output  1  1 = CUT inputs taken from TPG
tpg_clr  output  1  synchronous clear/seed of TPG
tpg_en  output  1  TPG advance enable
misr_clr  output  1  synchronous clear of MISR
misr_en  output  1  MISR capture enable
pattern_cnt  output  CNT_WIDTH  patterns applied so far in this run
busy  output  1  run in progress (CLEAR, RUN or COMPARE)
done  output  1  result valid
pass  output  1  signature matched GOLDEN_SIG
fail  output  1  signature mismatched

Behaviour:
- reset low: state=IDLE; every output is 0 and pattern_cnt=0, immediately and asynchronously. A reset mid-run discards the run.
- All outputs are registered. States: IDLE, CLEAR, RUN, COMPARE, DONE.
- IDLE: all outputs 0. start=1 moves to CLEAR.
- CLEAR (1 cycle):
  - bist_mode=1, tpg_clr=1, misr_clr=1, busy=1.
  - pass, fail and done are cleared; pattern_cnt=0.
  - Moves to RUN.
- RUN (exactly NUM_PATTERNS cycles):
  - bist_mode=1, tpg_en=1, misr_en=1, busy=1.
  - pattern_cnt increments on each edge while in RUN, reaching NUM_PATTERNS on the edge that leaves RUN.
  - The last RUN cycle has pattern_cnt=NUM_PATTERNS-1, then moves to COMPARE.
- COMPARE (1 cycle):
  - bist_mode=1, tpg_en=0, misr_en=0, busy=1.
  - The signature is sampled on this state's closing edge: pass<=(signature==GOLDEN_SIG), fail<=~that.
  - Moves to DONE.
- DONE:
  - done=1; pass/fail held; bist_mode=0; pattern_cnt holds NUM_PATTERNS.
  - start=1 moves to CLEAR (re-run); otherwise stays in DONE.
- Latency: with start sampled at edge 0, CLEAR follows edge 0, RUN spans edges 1..NUM_PATTERNS, COMPARE follows edge NUM_PATTERNS+1, and done=1 from edge NUM_PATTERNS+2.
- start is ignored while busy=1.
- abort=1 in any state moves to IDLE on the next edge, with all outputs 0. abort has priority over start when both are high.
- pass and fail are never both 1; both are 0 whenever done=0.
- The counter never wraps within a run; the CNT_WIDTH constraint guarantees this.

Decomposition:
- Package bist_pkg holds the state enum (IDLE, CLEAR, RUN, COMPARE, DONE), the default SIG_WIDTH and the default GOLDEN_SIG constant. The TPG and MISR blocks share these.
- Sub-module bist_pattern_counter: a clearable, enabled up-counter with a terminal flag (count==NUM_PATTERNS-1). It is instantiated once. The FSM stays in bist_controller.

Test Plan:
- Reset then hold: reset=0 for 10 ns, then 1, start=0 for 50 ns → all outputs 0, pattern_cnt=0.
- Golden run: pulse start for 1 cycle while the bench holds signature=4'b1011 → CLEAR for 1 cycle with tpg_clr=misr_clr=1, then tpg_en=misr_en=1 for exactly 8 cycles, then done=1 and pass=1 and fail=0 exactly 10 edges after start; pattern_cnt=8.
- Faulty signature: same stimulus with signature=4'b1010 in COMPARE → done=1, pass=0, fail=1.
- Abort mid-run: abort=1 at pattern_cnt=3 → next edge IDLE, all outputs 0; a following start gives a full 8-pattern run.
- Reset mid-run: reset=0 asynchronously at pattern_cnt=5 → outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE.
- Restart and ignore: start held high during RUN has no effect; start in DONE causes CLEAR on the next edge, clearing done, pass and fail.
